// File: rtl/ntt_job_scheduler.sv
// Host-side sequencer for one ntt_processor: loads a job, pulses start, checks the output window.
// Optional watchdog in RUN/DRAIN is enabled by defining NTT_SCHED_TIMEOUT_EN.
module ntt_job_scheduler #(
   parameter int WORDS     = 2048,
   parameter int ADDR_W    = 11,
   parameter int DATA_W    = 60,
   parameter int OUT_BEATS = 32,
   parameter int START_GAP = 2
`ifdef NTT_SCHED_TIMEOUT_EN
   ,
   parameter int TIMEOUT   = 4095
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              ntt_write_enable,
   output logic [ADDR_W-1:0] ntt_address_in,
   output logic [DATA_W-1:0] ntt_data_in,
   output logic              ntt_start,
   input  logic              ntt_output_active,
   output logic              busy,
   output logic              done,
   output logic [2:0]        status
);

   typedef enum logic [2:0] {IDLE, LOAD, GAP, START, RUN, DRAIN, DONE} state_t;

   localparam int GAP_W  = (START_GAP > 1) ? $clog2(START_GAP) : 1;
   localparam int BEAT_W = $clog2(OUT_BEATS + 2);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(START_GAP - 1);
   localparam logic [BEAT_W-1:0] BEAT_REQ  = BEAT_W'(OUT_BEATS);
   localparam logic [BEAT_W-1:0] BEAT_MAX  = BEAT_W'(OUT_BEATS + 1);

   state_t            state;
   logic [ADDR_W-1:0] word_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic [BEAT_W-1:0] beat_cnt;
   logic              act_q;
   logic              wd_expired;

`ifdef NTT_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_cnt;

   // Counts cycles spent waiting on the processor; cleared in every other state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wd_cnt <= '0;
      else if (state == RUN || state == DRAIN)
         wd_cnt <= wd_cnt + 1'b1;
      else
         wd_cnt <= '0;
   end

   assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
`else
   assign wd_expired = 1'b0;
`endif

   // NOTE: every state and output register uses <=, so all reads in this block see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         word_cnt         <= '0;
         gap_cnt          <= '0;
         beat_cnt         <= '0;
         act_q            <= 1'b0;
         s_ready          <= 1'b0;
         ntt_write_enable <= 1'b0;
         ntt_address_in   <= '0;
         ntt_data_in      <= '0;
         ntt_start        <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         status           <= '0;
      end else begin
         act_q            <= ntt_output_active;
         ntt_write_enable <= 1'b0;
         ntt_start        <= 1'b0;
         done             <= 1'b0;

         case (state)
            IDLE: begin
               if (s_valid) begin
                  state    <= LOAD;
                  s_ready  <= 1'b1;
                  busy     <= 1'b1;
                  word_cnt <= '0;
                  status   <= '0;
               end
            end

            LOAD: begin
               if (s_valid && s_ready) begin
                  ntt_write_enable <= 1'b1;
                  ntt_address_in   <= word_cnt;
                  ntt_data_in      <= s_data;
                  word_cnt         <= word_cnt + 1'b1;
                  if (s_last != (word_cnt == LAST_ADDR))
                     status[0] <= 1'b1;
                  // Job length is fixed; s_last only feeds the framing check.
                  if (word_cnt == LAST_ADDR) begin
                     state   <= GAP;
                     s_ready <= 1'b0;
                     gap_cnt <= '0;
                  end
               end
            end

            GAP: begin
               if (gap_cnt == GAP_LAST)
                  state <= START;
               else
                  gap_cnt <= gap_cnt + 1'b1;
            end

            START: begin
               ntt_start <= 1'b1;
               state     <= RUN;
            end

            RUN: begin
               if (wd_expired) begin
                  status[2] <= 1'b1;
                  done      <= 1'b1;
                  state     <= DONE;
               end else if (ntt_output_active && !act_q) begin
                  beat_cnt <= BEAT_W'(1);
                  state    <= DRAIN;
               end
            end

            DRAIN: begin
               if (wd_expired) begin
                  status[2] <= 1'b1;
                  done      <= 1'b1;
                  state     <= DONE;
               end else if (ntt_output_active) begin
                  // Saturate so a stuck-high window can never wrap back to a legal count.
                  if (beat_cnt != BEAT_MAX)
                     beat_cnt <= beat_cnt + 1'b1;
               end else begin
                  if (beat_cnt != BEAT_REQ)
                     status[1] <= 1'b1;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end

            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ntt_job_scheduler.sv
// Scoreboard bench for ntt_job_scheduler: expected writes and job status are queued at stimulus
// time and popped when the DUT writes or signals done; a small processor model drives output_active.
module tb_ntt_job_scheduler;

   localparam int WORDS      = 2048;
   localparam int ADDR_W     = 11;
   localparam int DATA_W     = 60;
   localparam int OUT_BEATS  = 32;
   localparam int START_GAP  = 2;
   localparam int TB_TIMEOUT = 100;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              s_last;
   logic              ntt_write_enable;
   logic [ADDR_W-1:0] ntt_address_in;
   logic [DATA_W-1:0] ntt_data_in;
   logic              ntt_start;
   logic              ntt_output_active;
   logic              busy;
   logic              done;
   logic [2:0]        status;

   ntt_job_scheduler #(
      .WORDS    (WORDS),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .OUT_BEATS(OUT_BEATS),
      .START_GAP(START_GAP)
`ifdef NTT_SCHED_TIMEOUT_EN
      ,
      .TIMEOUT  (TB_TIMEOUT)
`endif
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .s_valid          (s_valid),
      .s_ready          (s_ready),
      .s_data           (s_data),
      .s_last           (s_last),
      .ntt_write_enable (ntt_write_enable),
      .ntt_address_in   (ntt_address_in),
      .ntt_data_in      (ntt_data_in),
      .ntt_start        (ntt_start),
      .ntt_output_active(ntt_output_active),
      .busy             (busy),
      .done             (done),
      .status           (status)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t        wr_q[$];
   logic [2:0] st_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_wr_cyc = 0;
   int start_cyc = 0;
   int fall_cyc = 0;
   int start_cnt = 0;
   int done_cnt = 0;
   int model_beats = OUT_BEATS;
   bit model_on = 1'b1;
   logic act_d = 1'b0;
   logic [2:0] exp_st;
   wr_t exp_wr;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      act_d <= ntt_output_active;
      if (act_d && !ntt_output_active)
         fall_cyc <= cyc;
   end

   // Output monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ntt_write_enable) begin
            check("write_expected", 64'(wr_q.size() != 0), 64'd1);
            if (wr_q.size() != 0) begin
               exp_wr = wr_q.pop_front();
               check("wr_addr", 64'(ntt_address_in), 64'(exp_wr.addr));
               check("wr_data", 64'(ntt_data_in), 64'(exp_wr.data));
            end
            last_wr_cyc = cyc;
         end
         if (ntt_start) begin
            start_cnt++;
            start_cyc = cyc;
            check("start_after_last_write", 64'(cyc - last_wr_cyc), 64'd3);
         end
         if (done) begin
            done_cnt++;
            check("done_expected", 64'(st_q.size() != 0), 64'd1);
            if (st_q.size() != 0) begin
               exp_st = st_q.pop_front();
               check("status", 64'(status), 64'(exp_st));
               if (exp_st[2])
                  check("timeout_latency", 64'(cyc - start_cyc), 64'(TB_TIMEOUT));
               else
                  check("done_after_fall", 64'(cyc - fall_cyc), 64'd1);
            end
         end
      end
   end

   // Processor model: output window of model_beats cycles a few cycles after each start.
   initial begin
      ntt_output_active = 1'b0;
      forever begin
         @(negedge clk);
         if (ntt_start && model_on) begin
            repeat (5) @(negedge clk);
            ntt_output_active = 1'b1;
            repeat (model_beats) @(negedge clk);
            ntt_output_active = 1'b0;
         end
      end
   end

   task automatic send_job(input int last_beat, input bit stall, input int abort_beat);
      int beat = 0;
      int guard = 0;
      while (beat < WORDS && guard < 20 * WORDS) begin
         @(negedge clk);
         guard++;
         if (beat == abort_beat) begin
            s_valid = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            check("rst_s_ready", 64'(s_ready), 64'd0);
            check("rst_write_enable", 64'(ntt_write_enable), 64'd0);
            check("rst_address", 64'(ntt_address_in), 64'd0);
            check("rst_data", 64'(ntt_data_in), 64'd0);
            check("rst_start", 64'(ntt_start), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_status", 64'(status), 64'd0);
            wr_q.delete();
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         s_valid = !(stall && $urandom_range(0, 2) == 0);
         s_data  = DATA_W'({$urandom(), $urandom()});
         s_last  = (beat == last_beat);
         if (s_valid && s_ready) begin
            wr_q.push_back('{addr: ADDR_W'(beat), data: s_data});
            beat++;
         end
      end
      check("load_completed", 64'(beat), 64'(WORDS));
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int target = done_cnt + 1;
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", 64'(done_cnt >= target), 64'd1);
   endtask

   task automatic run_job(input int last_beat, input bit stall, input logic [2:0] exp_status);
      int starts0 = start_cnt;
      st_q.push_back(exp_status);
      send_job(last_beat, stall, -1);
      wait_done(1000);
      check("start_pulses", 64'(start_cnt - starts0), 64'd1);
      check("words_left", 64'(wr_q.size()), 64'd0);
      @(negedge clk);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_s_ready", 64'(s_ready), 64'd0);
   endtask

   int d0;

   initial begin
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
      repeat (3) @(negedge clk);
      check("reset_s_ready", 64'(s_ready), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_write_enable", 64'(ntt_write_enable), 64'd0);
      check("reset_start", 64'(ntt_start), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_status", 64'(status), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_job(WORDS - 1, 1'b0, 3'b000);    // nominal
      run_job(WORDS - 1, 1'b1, 3'b000);    // stalled load
      run_job(100, 1'b0, 3'b001);          // s_last early
      run_job(-1, 1'b0, 3'b001);           // s_last never

      model_beats = OUT_BEATS - 1;
      run_job(WORDS - 1, 1'b0, 3'b010);
      model_beats = OUT_BEATS;

      send_job(WORDS - 1, 1'b0, 500);      // reset mid-load
      repeat (2) @(negedge clk);
      run_job(WORDS - 1, 1'b0, 3'b000);

      model_on = 1'b0;
`ifdef NTT_SCHED_TIMEOUT_EN
      run_job(WORDS - 1, 1'b0, 3'b100);
`else
      d0 = done_cnt;
      send_job(WORDS - 1, 1'b0, -1);
      repeat (300) @(negedge clk);
      check("busy_without_watchdog", 64'(busy), 64'd1);
      check("no_done_without_watchdog", 64'(done_cnt - d0), 64'd0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
`endif
      model_on = 1'b1;

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ntt_job_scheduler.md
# ntt_job_scheduler

Sequencer that owns the host-facing side of one `ntt_processor` instance. It accepts a coefficient stream for one transform over a valid/ready handshake and writes it into the processor's memory. It then pulses `start`, tracks the processor's output window and reports completion and status per job. It sits between the host DMA/stream fabric and the processor, one instance per modulus lane.

## Interface
Parameters:
- `WORDS`, 2048: 60-bit load words per job (two 30-bit coefficients each).
- `ADDR_W`, 11: processor load-address width; `2**ADDR_W >= WORDS`.
- `DATA_W`, 60: load word width.
- `OUT_BEATS`, 32: expected cycles of `output_active` high per job (LOG_CORE_COUNT=5).
- `START_GAP`, 2: idle cycles between last load write and `start` (drains processor input registers).
- `TIMEOUT`, 4095: watchdog limit in cycles (only with `NTT_SCHED_TIMEOUT_EN`).

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `s_valid` in 1: load word valid.
- `s_ready` out 1: scheduler can take a word.
- `s_data` in DATA_W: load word.
- `s_last` in 1: host marks final word of job.
- `ntt_write_enable` out 1: to processor `write_enable`.
- `ntt_address_in` out ADDR_W: to processor `address_in`.
- `ntt_data_in` out DATA_W: to processor `data_in`.
- `ntt_start` out 1: to processor `start`, one-cycle pulse.
- `ntt_output_active` in 1: from processor `output_active`.
- `busy` out 1: job in progress (any state but IDLE).
- `done` out 1: one-cycle completion pulse.
- `status` out 3: valid with `done`; bit0 framing error, bit1 drain-length error, bit2 timeout.

## Operation
- States: IDLE, LOAD, GAP, START, RUN, DRAIN, DONE.
- IDLE: `s_ready`=0 and `busy`=0. Moves to LOAD when `s_valid`=1. The first word is not consumed in IDLE.
- LOAD: `s_ready`=1. Each handshake (`s_valid & s_ready`) registers `ntt_write_enable`=1, `ntt_data_in`=`s_data`, `ntt_address_in`=word counter. The counter starts at 0 and increments per beat. Stalls (`s_valid`=0) drive `ntt_write_enable`=0 with address and data held.
- On the beat with counter = WORDS-1, the block goes to GAP and `s_ready` drops the next cycle. `s_last` is not used to end the load.
- Framing error (status bit0) is set if `s_last`=1 on any beat other than WORDS-1, or if `s_last`=0 on beat WORDS-1.
- GAP: `ntt_write_enable`=0 for START_GAP cycles, then START.
- START: `ntt_start`=1 for exactly one cycle, then RUN.
- RUN: waits for `ntt_output_active` rising (0 then 1) and enters DRAIN on that cycle with beat counter = 1.
- DRAIN: counts cycles with `ntt_output_active`=1. When `ntt_output_active` falls, drain-length error (bit1) is set if count ≠ OUT_BEATS, then DONE.
- DONE: `done`=1 and `status` valid for one cycle, then IDLE. Status flags clear on entry to LOAD.
- `ntt_output_active` high in any state other than RUN/DRAIN is ignored.
- Reset mid-job returns to IDLE immediately. Partial processor memory contents are not cleaned; the next job overwrites all WORDS locations.

## Timing
- Reset values: `s_ready`=0, `ntt_write_enable`=0, `ntt_address_in`=0, `ntt_data_in`=0, `ntt_start`=0, `busy`=0, `done`=0, `status`=0.
- All outputs are registered. A handshake at edge n gives `ntt_write_enable`/address/data valid from edge n to n+1.
- A full-rate load takes WORDS cycles, plus START_GAP, plus 1 start cycle.
- `done` is asserted the cycle after the `ntt_output_active` falling edge is sampled.
- IDLE to LOAD costs one cycle. Back-to-back jobs therefore have a one-cycle DONE bubble plus one IDLE cycle.

## Configuration
- `NTT_SCHED_TIMEOUT_EN` defined: a watchdog counts cycles in RUN and DRAIN.
  - When the count reaches TIMEOUT, the block sets status bit2 and goes to DONE.
  - If `ntt_output_active` is still high at that point, the job is abandoned.
- Macro undefined: no watchdog, no timeout counter, and status bit2 is tied to 0. RUN waits indefinitely.

## Test plan
- Nominal job:
  - Stimulus: 2048 beats at full rate, `s_last` on beat 2047; a processor model raises `output_active` 32 cycles.
  - Required response: addresses 0..2047 in order; one `ntt_start` pulse exactly 3 cycles after the last write; `done` with `status`=0.
- Stalled load: `s_valid` toggled pseudo-randomly → no write on stall cycles, no skipped or duplicated address, data matches beat order.
- Framing:
  - `s_last` on beat 100 → load still runs to 2048 words; `status`=3'b001.
  - No `s_last` at all → `status`=3'b001.
- Drain mismatch: model gives 31 active cycles → `done` one cycle after the fall, `status`=3'b010.
- Reset mid-LOAD: `rst_n` low at beat 500 → all outputs at reset values asynchronously; the next job starts again at address 0.
- Timeout (macro on, TIMEOUT=100): model never raises `output_active` → `done` 100 cycles after entering RUN with `status`=3'b100. With the macro off, `busy` stays high.
